// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced by pixel_tick,
// decoded into a registered, mutually aligned position/blanking/sync bundle.
module vga_timing_gen #(
  parameter int H_VIS      = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_VIS      = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_tick,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS_C  = 12'(H_VIS);
  localparam logic [11:0] V_VIS_C  = 12'(V_VIS);
  localparam logic [11:0] HS_BEGIN = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEGIN = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_VIS + V_FP + V_SYNC);

  logic [11:0] h_cnt_p0;
  logic [11:0] v_cnt_p0;
  logic        vis_p0;
  logic        hs_act_p0;
  logic        vs_act_p0;
  logic        origin_p0;

  function automatic logic in_span(input logic [11:0] x,
                                   input logic [11:0] lo,
                                   input logic [11:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // Stage p0: raw counters and their combinational decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (pixel_tick) begin
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 12'd0 : v_cnt_p0 + 12'd1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 12'd1;
      end
    end
  end

  always_comb begin
    vis_p0    = (h_cnt_p0 < H_VIS_C) && (v_cnt_p0 < V_VIS_C);
    hs_act_p0 = in_span(h_cnt_p0, HS_BEGIN, HS_END);
    // vsync follows the line counter only, so it can only change at column wrap
    vs_act_p0 = in_span(v_cnt_p0, VS_BEGIN, VS_END);
    origin_p0 = (h_cnt_p0 == 12'd0) && (v_cnt_p0 == 12'd0);
  end

  // Stage p1: output registers, all loaded on the same tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_column <= '0;
      pixel_row    <= '0;
      video_on     <= 1'b0;
      horiz_sync   <= ~H_SYNC_POL;
      vert_sync    <= ~V_SYNC_POL;
      frame_start  <= 1'b0;
    end else if (pixel_tick) begin
      pixel_column <= h_cnt_p0;
      pixel_row    <= v_cnt_p0;
      video_on     <= vis_p0;
      horiz_sync   <= sync_level(hs_act_p0, H_SYNC_POL);
      vert_sync    <= sync_level(vs_act_p0, V_SYNC_POL);
      frame_start  <= origin_p0;
    end else begin
      // strobe is exactly one clock wide even when ticks are sparse
      frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster (H 4/1/2/1, V 3/1/1/1,
// active-high syncs): 8 columns x 6 rows, every clock compared to a model.
module tb_vga_timing_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_tick = 1'b0;
  logic [11:0] pixel_column;
  logic [11:0] pixel_row;
  logic        video_on;
  logic        horiz_sync;
  logic        vert_sync;
  logic        frame_start;

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_tick  (pixel_tick),
    .pixel_column(pixel_column),
    .pixel_row   (pixel_row),
    .video_on    (video_on),
    .horiz_sync  (horiz_sync),
    .vert_sync   (vert_sync),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        hs;
    logic        vs;
    logic        fs;
  } pix_t;

  // Hand-derived per-column / per-row decode tables (bit i = column or row i).
  // Visible columns 0..3, hsync columns 5..6; visible rows 0..2, vsync row 4.
  logic [7:0] von_col = 8'b0000_1111;
  logic [7:0] hs_col  = 8'b0110_0000;
  logic [5:0] von_row = 6'b00_0111;
  logic [5:0] vs_row  = 6'b01_0000;

  pix_t exp_q[$];
  pix_t cur;
  int   mh = 0;
  int   mv = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic model_reset();
    mh = 0;
    mv = 0;
    cur = '0;
  endtask

  task automatic model_edge(input logic t);
    if (t) begin
      cur.col = 12'(mh);
      cur.row = 12'(mv);
      cur.von = von_col[mh] & von_row[mv];
      cur.hs  = hs_col[mh];
      cur.vs  = vs_row[mv];
      cur.fs  = (mh == 0) && (mv == 0);
      mh++;
      if (mh == 8) begin
        mh = 0;
        mv++;
        if (mv == 6) mv = 0;
      end
    end else begin
      cur.fs = 1'b0;
    end
  endtask

  // Called just after a rising edge: drive inputs, queue what the DUT must show
  // at the next falling edge, then account for the following rising edge.
  task automatic cycle(input logic r, input logic t);
    reset = r;
    pixel_tick = t;
    if (r) model_reset();
    exp_q.push_back(cur);
    @(posedge clock);
    if (!r) model_edge(t);
    #1;
  endtask

  // Monitor: one expected entry per clock, compared mid-cycle
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      pix_t e;
      pix_t a;
      e = exp_q.pop_front();
      a = '{pixel_column, pixel_row, video_on, horiz_sync, vert_sync, frame_start};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL pix t=%0t got col=%0d row=%0d von=%b hs=%b vs=%b fs=%b want col=%0d row=%0d von=%b hs=%b vs=%b fs=%b",
                 $time, a.col, a.row, a.von, a.hs, a.vs, a.fs,
                 e.col, e.row, e.von, e.hs, e.vs, e.fs);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    // Reset state, then two full frames plus a few pixels with continuous ticks
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 2 * 48 + 5; i++) cycle(1'b0, 1'b1);
    // Mid-frame reset for 3 clocks with ticks present; takes effect before any edge
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    // Sparse ticks: one every 4th clock for two frames; outputs hold in between
    for (int i = 0; i < 4 * 96; i++) cycle(1'b0, (i % 4) == 3);
    // Advance to the wrap pixel, then reset on the wrap tick
    for (int i = 0; i < 100 && !(mh == 7 && mv == 5); i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d entries left want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
